// File: rtl/idma_error_unit.sv
// rtl/idma_error_unit.sv - first-error capture, report/action handshake and in-flight burst tracking
module idma_error_unit #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned NumOutstanding = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 burst_issue_i,
  input  logic                 burst_done_i,
  output logic                 cnt_full_o,
  input  logic                 r_err_i,
  input  logic [AddrWidth-1:0] r_err_addr_i,
  input  logic                 w_err_i,
  input  logic [AddrWidth-1:0] w_err_addr_i,
  output logic                 err_valid_o,
  input  logic                 err_ready_i,
  output logic [1:0]           err_type_o,
  output logic [AddrWidth-1:0] err_addr_o,
  input  logic                 eh_valid_i,
  output logic                 eh_ready_o,
  input  logic                 eh_i,
  output logic                 halt_o,
  output logic                 abort_o,
  output logic                 eh_fsm_busy_o,
  output logic                 eh_cnt_busy_o
);

  localparam int unsigned          CntWidth = $clog2(NumOutstanding + 1);
  localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(NumOutstanding);
  localparam logic [1:0]           BusRead  = 2'd0;
  localparam logic [1:0]           BusWrite = 2'd1;
  localparam logic                 EhAbort  = 1'b1;

  typedef enum logic [1:0] {IDLE, REPORT, WAIT_EH, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [1:0]             err_type_q, err_type_d;
  logic [AddrWidth-1:0]   err_addr_q, err_addr_d;

  // Saturating in-flight counter; issue and done in the same cycle cancel out
  always_comb begin
    cnt_d = cnt_q;
    if (burst_issue_i && !burst_done_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!burst_issue_i && burst_done_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    err_type_d  = err_type_q;
    err_addr_d  = err_addr_q;
    err_valid_o = 1'b0;
    eh_ready_o  = 1'b0;
    abort_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (r_err_i) begin
          err_type_d = BusRead;
          err_addr_d = r_err_addr_i;
          state_d    = REPORT;
        end else if (w_err_i) begin
          err_type_d = BusWrite;
          err_addr_d = w_err_addr_i;
          state_d    = REPORT;
        end
      end
      REPORT: begin
        err_valid_o = 1'b1;
        if (err_ready_i) state_d = WAIT_EH;
      end
      WAIT_EH: begin
        eh_ready_o = 1'b1;
        if (eh_valid_i) begin
          if (eh_i == EhAbort) begin
            abort_o = 1'b1;
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        // Leave once the bus is drained, counting this cycle's completions
        if (cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_type_q <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_type_q <= err_type_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_type_o    = err_type_q;
  assign err_addr_o    = err_addr_q;
  assign halt_o        = (state_q != IDLE);
  assign eh_fsm_busy_o = halt_o;
  assign cnt_full_o    = (cnt_q == CntMax);
  assign eh_cnt_busy_o = (cnt_q != '0);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(burst_issue_i && !burst_done_i && cnt_full_o));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(burst_done_i && !burst_issue_i && !eh_cnt_busy_o));

endmodule

// File: tb/tb_idma_error_unit.sv
// tb/tb_idma_error_unit.sv - vector table, corner sequences and random run against a reference model
module tb_idma_error_unit;

  localparam logic [1:0] BUS_READ  = 2'd0;
  localparam logic [1:0] BUS_WRITE = 2'd1;

  logic        clk_i, rst_ni;
  logic        burst_issue_i, burst_done_i, cnt_full_o;
  logic        r_err_i, w_err_i;
  logic [63:0] r_err_addr_i, w_err_addr_i, err_addr_o;
  logic        err_valid_o, err_ready_i;
  logic [1:0]  err_type_o;
  logic        eh_valid_i, eh_ready_o, eh_i;
  logic        halt_o, abort_o, eh_fsm_busy_o, eh_cnt_busy_o;

  idma_error_unit #(.AddrWidth(64), .NumOutstanding(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .burst_issue_i(burst_issue_i), .burst_done_i(burst_done_i), .cnt_full_o(cnt_full_o),
    .r_err_i(r_err_i), .r_err_addr_i(r_err_addr_i),
    .w_err_i(w_err_i), .w_err_addr_i(w_err_addr_i),
    .err_valid_o(err_valid_o), .err_ready_i(err_ready_i),
    .err_type_o(err_type_o), .err_addr_o(err_addr_o),
    .eh_valid_i(eh_valid_i), .eh_ready_o(eh_ready_o), .eh_i(eh_i),
    .halt_o(halt_o), .abort_o(abort_o),
    .eh_fsm_busy_o(eh_fsm_busy_o), .eh_cnt_busy_o(eh_cnt_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        issue, done, r_err, w_err;
    logic [63:0] r_addr, w_addr;
    logic        err_ready, eh_valid, eh;
  } in_t;

  typedef struct packed {
    logic        r_err, w_err;
    logic [63:0] r_addr, w_addr;
    logic        err_ready, eh_valid, eh;
    logic        x_valid;
    logic [1:0]  x_type;
    logic [63:0] x_addr;
    logic        x_ready, x_abort, x_halt;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending report / awaiting action / draining after abort
  int          m_cnt;
  bit          m_rep, m_wait, m_flush;
  logic [1:0]  m_type;
  logic [63:0] m_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rep = 0; m_wait = 0; m_flush = 0; m_type = 2'd0; m_addr = 64'd0;
  endtask

  task automatic model_update(input in_t v);
    int nc;
    nc = m_cnt + int'(v.issue) - int'(v.done);
    if (nc < 0) nc = 0;
    if (nc > 8) nc = 8;
    if (m_flush) begin
      if (nc == 0) m_flush = 0;
    end else if (m_wait) begin
      if (v.eh_valid) begin
        m_wait  = 0;
        m_flush = v.eh;
      end
    end else if (m_rep) begin
      if (v.err_ready) begin
        m_rep  = 0;
        m_wait = 1;
      end
    end else if (v.r_err) begin
      m_rep = 1; m_type = BUS_READ; m_addr = v.r_addr;
    end else if (v.w_err) begin
      m_rep = 1; m_type = BUS_WRITE; m_addr = v.w_addr;
    end
    m_cnt = nc;
  endtask

  task automatic drive(input in_t v);
    burst_issue_i = v.issue;  burst_done_i = v.done;
    r_err_i       = v.r_err;  r_err_addr_i = v.r_addr;
    w_err_i       = v.w_err;  w_err_addr_i = v.w_addr;
    err_ready_i   = v.err_ready;
    eh_valid_i    = v.eh_valid;
    eh_i          = v.eh;
  endtask

  task automatic compare_model(input in_t v);
    logic busy;
    busy = m_rep | m_wait | m_flush;
    chk("m_valid",    err_valid_o,   m_rep);
    chk("m_type",     err_type_o,    m_type);
    chk("m_addr",     err_addr_o,    m_addr);
    chk("m_eh_ready", eh_ready_o,    m_wait);
    chk("m_abort",    abort_o,       m_wait & v.eh_valid & v.eh);
    chk("m_halt",     halt_o,        busy);
    chk("m_fsm_busy", eh_fsm_busy_o, busy);
    chk("m_cnt_busy", eh_cnt_busy_o, m_cnt != 0);
    chk("m_cnt_full", cnt_full_o,    m_cnt == 8);
  endtask

  // One clock cycle: drive after the falling edge, check before the rising edge
  task automatic tick(input in_t v);
    @(negedge clk_i);
    drive(v);
    #1;
    compare_model(v);
    model_update(v);
  endtask

  vec_t vecs[10];
  in_t  v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 64'h1000, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, BUS_READ, 64'h0,    1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b0, 1'b0, 1'b1, BUS_READ, 64'h1000, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 64'h0,    64'h55, 1'b1, 1'b0, 1'b0, 1'b1, BUS_READ, 64'h1000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b1, 1'b0, 1'b0, BUS_READ, 64'h1000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b1, 1'b1, 1'b0, BUS_READ, 64'h1000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 64'h10,   64'h20, 1'b0, 1'b0, 1'b0, 1'b0, BUS_READ, 64'h1000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 64'h0,    64'h0,  1'b1, 1'b0, 1'b0, 1'b1, BUS_READ, 64'h10,   1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 64'h0,    64'h99, 1'b0, 1'b1, 1'b0, 1'b0, BUS_READ, 64'h10,   1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b0, 1'b0, 1'b0, BUS_READ, 64'h10,   1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 64'h0,    64'h0,  1'b0, 1'b0, 1'b0, 1'b0, BUS_READ, 64'h10,   1'b0, 1'b0, 1'b0};

    // Reset state
    rst_ni = 1'b0;
    drive('0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", err_valid_o, 0);  chk("rst_type", err_type_o, 0);
    chk("rst_addr", err_addr_o, 0);    chk("rst_eh_ready", eh_ready_o, 0);
    chk("rst_abort", abort_o, 0);      chk("rst_halt", halt_o, 0);
    chk("rst_fsm_busy", eh_fsm_busy_o, 0);
    chk("rst_cnt_busy", eh_cnt_busy_o, 0);
    chk("rst_cnt_full", cnt_full_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Vector table: report, CONTINUE, read-over-write priority, ignored errors
    for (int i = 0; i < 10; i++) begin
      v = '0;
      v.r_err = vecs[i].r_err;  v.w_err = vecs[i].w_err;
      v.r_addr = vecs[i].r_addr; v.w_addr = vecs[i].w_addr;
      v.err_ready = vecs[i].err_ready; v.eh_valid = vecs[i].eh_valid; v.eh = vecs[i].eh;
      @(negedge clk_i);
      drive(v);
      #1;
      chk($sformatf("v%0d_valid", i),    err_valid_o,   vecs[i].x_valid);
      chk($sformatf("v%0d_type", i),     err_type_o,    vecs[i].x_type);
      chk($sformatf("v%0d_addr", i),     err_addr_o,    vecs[i].x_addr);
      chk($sformatf("v%0d_eh_ready", i), eh_ready_o,    vecs[i].x_ready);
      chk($sformatf("v%0d_abort", i),    abort_o,       vecs[i].x_abort);
      chk($sformatf("v%0d_halt", i),     halt_o,        vecs[i].x_halt);
      chk($sformatf("v%0d_fsm_busy", i), eh_fsm_busy_o, vecs[i].x_halt);
      model_update(v);
    end

    // ABORT with 3 bursts in flight; errors during FLUSH ignored
    v = '0; v.issue = 1;
    repeat (3) tick(v);
    v = '0; v.r_err = 1; v.r_addr = 64'hCAFE;
    tick(v);
    v = '0; v.err_ready = 1;
    tick(v);
    v = '0; v.eh_valid = 1; v.eh = 1;
    tick(v);
    chk("s4_abort_pulse", abort_o, 1);
    v = '0; v.done = 1; v.w_err = 1; v.w_addr = 64'hDEAD;
    tick(v);
    chk("s4_abort_once", abort_o, 0);
    chk("s4_flush_halt1", halt_o, 1);
    v = '0; v.done = 1; v.r_err = 1; v.r_addr = 64'hBEEF;
    tick(v);
    tick(v);
    chk("s4_flush_halt3", halt_o, 1);
    v = '0;
    tick(v);
    chk("s4_idle_halt", halt_o, 0);
    chk("s4_no_report", err_valid_o, 0);
    chk("s4_addr_kept", err_addr_o, 64'hCAFE);
    chk("s4_cnt_busy", eh_cnt_busy_o, 0);

    // ABORT with nothing in flight: FLUSH lasts one cycle
    v = '0; v.w_err = 1; v.w_addr = 64'h40;
    tick(v);
    v = '0; v.err_ready = 1;
    tick(v);
    v = '0; v.eh_valid = 1; v.eh = 1;
    tick(v);
    v = '0;
    tick(v);
    chk("s4b_flush_one", halt_o, 1);
    chk("s4b_flush_type", err_type_o, BUS_WRITE);
    tick(v);
    chk("s4b_flush_done", halt_o, 0);

    // Counter saturation and drain
    v = '0; v.issue = 1;
    repeat (7) tick(v);
    chk("s5_not_full7", cnt_full_o, 0);
    tick(v);
    v = '0;
    tick(v);
    chk("s5_full", cnt_full_o, 1);
    v = '0; v.issue = 1; v.done = 1;
    tick(v);
    v = '0;
    tick(v);
    chk("s5_full_kept", cnt_full_o, 1);
    v = '0; v.done = 1;
    repeat (8) tick(v);
    v = '0;
    tick(v);
    chk("s5_drained", eh_cnt_busy_o, 0);
    chk("s5_not_full", cnt_full_o, 0);

    // Asynchronous reset while waiting for an action
    v = '0; v.issue = 1;
    repeat (2) tick(v);
    v = '0; v.r_err = 1; v.r_addr = 64'h77;
    tick(v);
    v = '0; v.err_ready = 1;
    tick(v);
    v = '0;
    tick(v);
    chk("s6_in_wait", eh_ready_o, 1);
    #2;
    v = '0; v.eh_valid = 1; v.eh = 1;
    drive(v);
    rst_ni = 1'b0;
    #1;
    chk("s6_valid", err_valid_o, 0);  chk("s6_type", err_type_o, 0);
    chk("s6_addr", err_addr_o, 0);    chk("s6_eh_ready", eh_ready_o, 0);
    chk("s6_abort", abort_o, 0);      chk("s6_halt", halt_o, 0);
    chk("s6_cnt_busy", eh_cnt_busy_o, 0);
    drive('0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    v = '0; v.w_err = 1; v.w_addr = 64'hABC;
    tick(v);
    v = '0;
    tick(v);
    chk("s6_bus_write", err_type_o, BUS_WRITE);
    chk("s6_w_addr", err_addr_o, 64'hABC);
    chk("s6_w_valid", err_valid_o, 1);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      v = '0;
      v.issue     = ($urandom % 3 == 0) && (m_cnt < 8);
      v.done      = ($urandom % 3 == 0) && (m_cnt > 0);
      v.r_err     = ($urandom % 10 == 0);
      v.w_err     = ($urandom % 10 == 0);
      v.r_addr    = {$urandom, $urandom};
      v.w_addr    = {$urandom, $urandom};
      v.err_ready = $urandom % 2;
      v.eh_valid  = $urandom % 2;
      v.eh        = $urandom % 2;
      tick(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
